// File: rtl/step_sched_pkg.sv
// Shared types and helpers for the step scheduler: FSM state encoding,
// statistics width and a saturating increment.
package step_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int STAT_W = 16;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/step_sched_rx_fifo.sv
// Synchronous return-packet FIFO with occupancy count and a registered
// almost-full flag that rises one entry before the queue is truly full.
module step_sched_rx_fifo #(
    parameter int PKT_W     = 32,
    parameter int RXQ_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [PKT_W-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [PKT_W-1:0]           rd_data,
    output logic [$clog2(RXQ_DEPTH):0] count,
    output logic                       almost_full
);
    localparam int AW = $clog2(RXQ_DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(RXQ_DEPTH);
    localparam logic [AW:0] AF_LVL   = (AW+1)'(RXQ_DEPTH - 1);

    logic [PKT_W-1:0] mem [RXQ_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count_nxt;
    logic             do_wr;
    logic             do_rd;

    // A pop frees the slot in the same cycle, so a push at full is taken then.
    assign do_rd = rd_en && (count != '0);
    assign do_wr = wr_en && ((count != FULL_LVL) || do_rd);

    always_comb begin
        count_nxt = count;
        if (do_wr && !do_rd) begin
            count_nxt = count + 1'b1;
        end else if (do_rd && !do_wr) begin
            count_nxt = count - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            almost_full <= 1'b0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            count       <= count_nxt;
            almost_full <= (count_nxt >= AF_LVL);
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/step_scheduler.sv
// Time-step scheduler: paces a run of fixed-length steps, injects stamped spikes
// into the router and buffers returned packets. Stats built under STEP_SCHED_STATS_EN.
module step_scheduler
    import step_sched_pkg::*;
#(
    parameter int STEP_NUMBER = 32,
    parameter int STEP_CYCLE  = 64,
    parameter int STEP_W      = 16,
    parameter int PKT_W       = 32,
    parameter int RXQ_DEPTH   = 4
) (
    input  logic              neu_clk,
    input  logic              rst_n,
    input  logic              go,
    input  logic              ev_valid,
    output logic              ev_ready,
    input  logic [PKT_W-1:0]  ev_packet,
    input  logic [STEP_W-1:0] ev_step,
    output logic [PKT_W-1:0]  tx_packet,
    output logic              tx_write_req,
    input  logic              tx_full,
    input  logic [PKT_W-1:0]  rx_packet,
    input  logic              rx_write_en,
    output logic              rx_full,
    output logic              rx_out_valid,
    input  logic              rx_out_ready,
    output logic [PKT_W-1:0]  rx_out_packet,
    output logic              start,
    output logic [STEP_W-1:0] cur_step,
    output logic              busy,
    output logic              done,
    output logic [STAT_W-1:0] late_cnt,
    output logic [STAT_W-1:0] tx_cnt,
    output logic [STAT_W-1:0] rx_cnt
);
    localparam int CYC_W = $clog2(STEP_CYCLE);
    localparam int CNT_W = $clog2(RXQ_DEPTH) + 1;
    localparam logic [CYC_W-1:0]  LAST_CYC  = CYC_W'(STEP_CYCLE - 1);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEP_NUMBER - 1);

    state_t            state;
    state_t            state_nxt;
    logic [CYC_W-1:0]  cycle_cnt;
    logic              run_go;
    logic              step_wrap;

    logic              head_valid;
    logic [PKT_W-1:0]  head_packet;
    logic [STEP_W-1:0] head_step;
    logic              ev_take;
    logic              head_late;
    logic              head_inject;

    logic [CNT_W-1:0]  rx_count;
    logic              rx_pop;

    assign step_wrap = (state == RUN) && (cycle_cnt == LAST_CYC);

    always_comb begin
        state_nxt = state;
        run_go    = 1'b0;
        case (state)
            IDLE: begin
                if (go) begin
                    state_nxt = RUN;
                    run_go    = 1'b1;
                end
            end
            RUN: begin
                if (step_wrap && (cur_step == LAST_STEP)) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge neu_clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cycle_cnt <= '0;
            cur_step  <= '0;
            start     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != IDLE);
            done  <= (state_nxt == DONE);
            start <= run_go || (step_wrap && (state_nxt == RUN));
            if (run_go) begin
                cycle_cnt <= '0;
                cur_step  <= '0;
            end else if (state == RUN) begin
                cycle_cnt <= step_wrap ? '0 : cycle_cnt + 1'b1;
                if (step_wrap && (state_nxt == RUN)) cur_step <= cur_step + 1'b1;
            end
        end
    end

    // Head disposition; the last cycle of a step never issues, and a strobe
    // in flight blocks the next one so strobes are at least two cycles apart.
    assign ev_ready    = !head_valid && ((state == IDLE) || (state == RUN));
    assign ev_take     = ev_valid && ev_ready;
    assign head_late   = (state == RUN) && head_valid && (head_step < cur_step);
    assign head_inject = (state == RUN) && head_valid && (head_step == cur_step) &&
                         (cycle_cnt != LAST_CYC) && !tx_full && !tx_write_req;

    always_ff @(posedge neu_clk or negedge rst_n) begin
        if (!rst_n) begin
            head_valid   <= 1'b0;
            tx_write_req <= 1'b0;
            tx_packet    <= '0;
        end else begin
            tx_write_req <= head_inject;
            if (head_inject) tx_packet <= head_packet;
            if (ev_take) begin
                head_valid <= 1'b1;
            end else if (head_late || head_inject) begin
                head_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge neu_clk) begin
        if (ev_take) begin
            head_packet <= ev_packet;
            head_step   <= ev_step;
        end
    end

    assign rx_out_valid = (rx_count != '0);
    assign rx_pop       = rx_out_valid && rx_out_ready;

    step_sched_rx_fifo #(
        .PKT_W     (PKT_W),
        .RXQ_DEPTH (RXQ_DEPTH)
    ) u_rx_fifo (
        .clk         (neu_clk),
        .rst_n       (rst_n),
        .wr_en       (rx_write_en),
        .wr_data     (rx_packet),
        .rd_en       (rx_pop),
        .rd_data     (rx_out_packet),
        .count       (rx_count),
        .almost_full (rx_full)
    );

`ifdef STEP_SCHED_STATS_EN
    localparam logic [CNT_W-1:0] RXQ_FULL = CNT_W'(RXQ_DEPTH);

    logic              rx_accept;
    logic [STAT_W-1:0] late_q;
    logic [STAT_W-1:0] tx_q;
    logic [STAT_W-1:0] rx_q;

    assign rx_accept = rx_write_en && ((rx_count != RXQ_FULL) || rx_pop);

    always_ff @(posedge neu_clk or negedge rst_n) begin
        if (!rst_n) begin
            late_q <= '0;
            tx_q   <= '0;
            rx_q   <= '0;
        end else if (run_go) begin
            late_q <= '0;
            tx_q   <= '0;
            rx_q   <= '0;
        end else begin
            if (head_late)   late_q <= sat_inc(late_q);
            if (head_inject) tx_q   <= sat_inc(tx_q);
            if (rx_accept)   rx_q   <= sat_inc(rx_q);
        end
    end

    assign late_cnt = late_q;
    assign tx_cnt   = tx_q;
    assign rx_cnt   = rx_q;
`else
    assign late_cnt = '0;
    assign tx_cnt   = '0;
    assign rx_cnt   = '0;
`endif

endmodule
